uart_tx_unit: RTL and testbench

UART transmitter. It is the upstream stage that drives the serial line into the receiver (RxUnit) through its data_tx input.
- Accepts one byte per valid/ready handshake.
- Serialises it as: start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Uses the same parity_type/baud_rate encodings as the receiver, so the two units loop back directly.
- System clock is 50 MHz.

---
 rtl/uart_tx_unit.sv | 153 +++++++++++++++
 tb/tb_uart_tx_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN for two stop bits; the default build sends one.
module uart_tx_unit #(
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            parity_type,
    input  logic [1:0]            baud_rate,
    output logic                  ready,
    output logic                  active_flag,
    output logic                  done_flag,
    output logic                  data_tx
);
    localparam int DIV_2400  = CLK_FREQ / 2400;
    localparam int DIV_4800  = CLK_FREQ / 4800;
    localparam int DIV_9600  = CLK_FREQ / 9600;
    localparam int DIV_19200 = CLK_FREQ / 19200;
    localparam int CNT_W     = (DIV_2400 > 2) ? $clog2(DIV_2400) : 1;
    localparam int IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_TX_TWO_STOP_EN
    localparam logic STOP_LAST = 1'b1;
`else
    localparam logic STOP_LAST = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  par_en_q, par_en_d;
    logic [1:0]            baud_q, baud_d;
    logic                  tx_q, tx_d;
    logic [CNT_W-1:0]      div_m1;
    logic                  bit_end;
    logic                  accept;

    always_comb begin
        div_m1 = CNT_W'(DIV_2400 - 1);
        case (baud_q)
            2'b00:   div_m1 = CNT_W'(DIV_2400 - 1);
            2'b01:   div_m1 = CNT_W'(DIV_4800 - 1);
            2'b10:   div_m1 = CNT_W'(DIV_9600 - 1);
            default: div_m1 = CNT_W'(DIV_19200 - 1);
        endcase
    end

    assign bit_end = (cnt_q == div_m1);
    assign accept  = (state_q == IDLE) && send;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (send) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end && idx_q == IDX_W'(DATA_WIDTH - 1))
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end && stop_q == STOP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready       = (state_q == IDLE);
        active_flag = (state_q != IDLE);
        done_flag   = (state_q == STOP) && bit_end && (stop_q == STOP_LAST);
    end

    // Config and payload are captured only at accept, so the frame in flight
    // is immune to later input changes.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        baud_d   = baud_q;
        if (accept) begin
            shift_d  = data_in;
            par_d    = (parity_type == 2'b01) ? ~^data_in : ^data_in;
            par_en_d = (parity_type == 2'b01) || (parity_type == 2'b10);
            baud_d   = baud_rate;
            cnt_d    = '0;
            idx_d    = '0;
            stop_d   = 1'b0;
        end else if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end && state_q == DATA) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 1'b1;
            end
            if (bit_end && state_q == STOP) begin
                stop_d = ~stop_q;
            end
        end
    end

    // Line level is derived from the next state so it changes on the same
    // edge as the state and comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            baud_q   <= 2'b00;
            tx_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            baud_q   <= baud_d;
            tx_q     <= tx_d;
        end
    end

    assign data_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Scoreboard bench for uart_tx_unit, run with a reduced CLK_FREQ so that
// the divisors are 40/20/10/5 clocks per bit.
module tb_uart_tx_unit;
    localparam int CLK_FREQ = 96000;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] parity_type = 2'b00;
    logic [1:0] baud_rate = 2'b00;
    logic       ready, active_flag, done_flag, data_tx;

    uart_tx_unit #(.CLK_FREQ(CLK_FREQ), .DATA_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .send(send), .data_in(data_in),
        .parity_type(parity_type), .baud_rate(baud_rate), .ready(ready),
        .active_flag(active_flag), .done_flag(done_flag), .data_tx(data_tx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ptype;
        logic [1:0] baud;
        bit         b2b;
        int         acc_cyc;
    } frame_t;

    frame_t sb[$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;
    bit     mon_busy = 1'b0;
    int     last_end = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int div_of(input logic [1:0] b);
        return CLK_FREQ / (2400 << b);
    endfunction

    // Monitor: decodes whatever frame appears on the line and compares it
    // with the oldest outstanding expectation.
    task automatic capture();
        frame_t     f;
        int         div, nbits, total, start, ones;
        bit         haspar;
        logic       par;
        logic       b [0:11];
        int         bad [0:11];
        int         done_bad, flag_bad;
        start = cyc;
        if (sb.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            return;
        end
        f      = sb.pop_front();
        div    = div_of(f.baud);
        haspar = (f.ptype == 2'b01) || (f.ptype == 2'b10);
        nbits  = 10 + (haspar ? 1 : 0) + (NSTOP - 1);
        total  = nbits * div;
        ones   = $countones(f.data);
        par    = (f.ptype == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
        for (int k = 0; k < 12; k++) begin
            bad[k] = 0;
            if (k == 0)               b[k] = 1'b0;
            else if (k <= 8)          b[k] = f.data[k-1];
            else if (haspar && k == 9) b[k] = par;
            else                      b[k] = 1'b1;
        end
        if (f.b2b) chk("idle_gap", start - last_end, 2);
        else       chk("latency", start, f.acc_cyc);
        done_bad = 0;
        flag_bad = 0;
        for (int t = 0; t < total; t++) begin
            if (t > 0) @(negedge clock);
            if (data_tx !== b[t / div]) bad[t / div]++;
            if (done_flag !== (t == total - 1)) done_bad++;
            if (ready !== 1'b0 || active_flag !== 1'b1) flag_bad++;
        end
        last_end = cyc;
        for (int k = 0; k < nbits; k++) chk($sformatf("bit%0d_bad_clocks", k), bad[k], 0);
        chk("done_bad_clocks", done_bad, 0);
        chk("busy_flag_bad_clocks", flag_bad, 0);
        @(negedge clock);
        chk("post_frame_idle", {data_tx, ready, active_flag, done_flag}, 4'b1100);
        $display("frame data=%02h ptype=%0d baud=%0d div=%0d bits=%0d", f.data, f.ptype, f.baud, div, nbits);
    endtask

    initial begin
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (mon_en && !reset && prev && data_tx === 1'b0) begin
                mon_busy = 1'b1;
                capture();
                mon_busy = 1'b0;
                prev = data_tx;
            end else begin
                prev = data_tx;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) chk("ready_timeout", 1, 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b, input bit push);
        frame_t fr;
        wait_ready();
        data_in = d;
        parity_type = p;
        baud_rate = b;
        send = 1'b1;
        fr.data = d; fr.ptype = p; fr.baud = b; fr.b2b = 1'b0; fr.acc_cyc = cyc + 1;
        if (push) sb.push_back(fr);
        @(negedge clock);
        send = 1'b0;
        data_in = 8'($urandom);
        parity_type = 2'($urandom);
        baud_rate = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        frame_t fr;
        int     dones;
        int     highs;
        repeat (3) @(negedge clock);
        chk("reset_held", {data_tx, ready, active_flag, done_flag}, 4'b1100);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_released", {data_tx, ready, active_flag, done_flag}, 4'b1100);
        mon_en = 1'b1;

        send_frame(8'h35, 2'b01, 2'b10, 1'b1);
        send_frame(8'h35, 2'b10, 2'b11, 1'b1);
        send_frame(8'hA5, 2'b11, 2'b00, 1'b1);
        wait_idle();

        // Short reset pulse while idle.
        reset = 1'b1;
        #1 chk("idle_reset_asserted", {data_tx, ready, active_flag, done_flag}, 4'b1100);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("idle_reset_released", {data_tx, ready, active_flag, done_flag}, 4'b1100);
        @(negedge clock);

        // Back-to-back with send held high, then a stray send mid-frame.
        wait_ready();
        data_in = 8'h0F; parity_type = 2'b00; baud_rate = 2'b11; send = 1'b1;
        fr.data = 8'h0F; fr.ptype = 2'b00; fr.baud = 2'b11; fr.b2b = 1'b0; fr.acc_cyc = cyc + 1;
        sb.push_back(fr);
        @(negedge clock);
        data_in = 8'hF0;
        fr.data = 8'hF0; fr.b2b = 1'b1; fr.acc_cyc = 0;
        sb.push_back(fr);
        wait_ready();
        @(negedge clock);
        send = 1'b0;
        repeat (20) @(negedge clock);
        data_in = 8'hAA; parity_type = 2'b01; send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        wait_idle();

        for (int i = 0; i < 12; i++)
            send_frame(8'($urandom), 2'($urandom), 2'($urandom), 1'b1);
        wait_idle();

        // Reset during data bit 3 (div 10: frame clocks 40..49).
        mon_en = 1'b0;
        send_frame(8'hF0, 2'b00, 2'b10, 1'b0);
        repeat (44) @(negedge clock);
        chk("pre_reset_line_bit3", data_tx, 1'b0);
        reset = 1'b1;
        #1 chk("async_reset_mid_frame", {data_tx, ready, active_flag, done_flag}, 4'b1100);
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        highs = 0;
        for (int t = 0; t < 150; t++) begin
            @(negedge clock);
            if (done_flag === 1'b1) dones++;
            if (data_tx === 1'b1) highs++;
        end
        chk("abandoned_done_pulses", dones, 0);
        chk("abandoned_line_high_clocks", highs, 150);
        mon_en = 1'b1;
        send_frame(8'h55, 2'b10, 2'b01, 1'b1);
        wait_idle();

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout actual=%0d required<%0d", cyc, 300000);
        $fatal(1, "watchdog");
    end

endmodule
